// File: rtl/multi_cycle_control_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and the
// MIPS datapath / shared memory.
interface multi_cycle_control_if;
  logic       Start;
  logic [5:0] OpCode;
  logic       Mem_ready;
  logic       PC_w;
  logic       IR_w;
  logic       I_or_D;
  logic       Mem_r;
  logic       Mem_w;
  logic       Reg_w;
  logic       Reg_dst;
  logic       Mem_to_reg;
  logic       ALU_src_a;
  logic [1:0] ALU_src_b;
  logic [1:0] ALU_op;
  logic       Instr_done;
  logic       Illegal;

  // Sequencer side: consumes opcode/handshake, drives datapath strobes.
  modport master (
    input  Start, OpCode, Mem_ready,
    output PC_w, IR_w, I_or_D, Mem_r, Mem_w, Reg_w, Reg_dst, Mem_to_reg,
           ALU_src_a, ALU_src_b, ALU_op, Instr_done, Illegal
  );

  // Datapath side: supplies opcode/handshake, obeys strobes.
  modport slave (
    output Start, OpCode, Mem_ready,
    input  PC_w, IR_w, I_or_D, Mem_r, Mem_w, Reg_w, Reg_dst, Mem_to_reg,
           ALU_src_a, ALU_src_b, ALU_op, Instr_done, Illegal
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control sequencer: steps R-type, addiu, lw, sw and ori
// through FETCH/DECODE/EXEC/MEM/WB over a handshaked shared memory.
module multi_cycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  multi_cycle_control_if.master       bus
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM_RD = 3'd4,
    MEM_WR = 3'd5,
    WB_ALU = 3'd6,
    WB_MEM = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  logic       pc_w, ir_w, i_or_d, mem_r, mem_w, reg_w, reg_dst, mem_to_reg;
  logic       alu_src_a, instr_done;
  logic [1:0] alu_src_b, alu_op;

  // State, latched opcode and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and strobe decode; strobes follow state/op_q, with
  // Mem_ready gating only the memory-completion strobes.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    illegal_d  = illegal_q;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    i_or_d     = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = FETCH;
      end
      FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        ir_w      = bus.Mem_ready;
        pc_w      = bus.Mem_ready;
        if (bus.Mem_ready) state_d = DECODE;
      end
      DECODE: begin
        op_d = bus.OpCode;
        case (bus.OpCode)
          OP_R, OP_ADDIU, OP_LW, OP_SW, OP_ORI: state_d = EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = IDLE;
          end
        endcase
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (op_q)
          OP_R: begin
            alu_src_b = 2'b00;
            alu_op    = 2'b10;
            state_d   = WB_ALU;
          end
          OP_ADDIU: begin
            alu_src_b = 2'b10;
            state_d   = WB_ALU;
          end
          OP_LW: begin
            alu_src_b = 2'b10;
            state_d   = MEM_RD;
          end
          OP_SW: begin
            alu_src_b = 2'b10;
            state_d   = MEM_WR;
          end
          OP_ORI: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = WB_ALU;
          end
          default: state_d = IDLE;
        endcase
      end
      MEM_RD: begin
        mem_r  = 1'b1;
        i_or_d = 1'b1;
        if (bus.Mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        mem_w      = 1'b1;
        i_or_d     = 1'b1;
        instr_done = bus.Mem_ready;
        if (bus.Mem_ready) state_d = FETCH;
      end
      WB_ALU: begin
        reg_w      = 1'b1;
        reg_dst    = (op_q == OP_R);
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      WB_MEM: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.PC_w       = pc_w;
  assign bus.IR_w       = ir_w;
  assign bus.I_or_D     = i_or_d;
  assign bus.Mem_r      = mem_r;
  assign bus.Mem_w      = mem_w;
  assign bus.Reg_w      = reg_w;
  assign bus.Reg_dst    = reg_dst;
  assign bus.Mem_to_reg = mem_to_reg;
  assign bus.ALU_src_a  = alu_src_a;
  assign bus.ALU_src_b  = alu_src_b;
  assign bus.ALU_op     = alu_op;
  assign bus.Instr_done = instr_done;
  assign bus.Illegal    = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle strobe vectors for each
// instruction class, memory waits, illegal opcode and mid-access reset.
module tb_multi_cycle_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multi_cycle_control_if bus ();

  multi_cycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: PC_w IR_w I_or_D Mem_r Mem_w Reg_w Reg_dst Mem_to_reg
  //                  ALU_src_a ALU_src_b[1:0] ALU_op[1:0] Instr_done Illegal
  logic [14:0] obs;
  assign obs = {bus.PC_w, bus.IR_w, bus.I_or_D, bus.Mem_r, bus.Mem_w, bus.Reg_w,
                bus.Reg_dst, bus.Mem_to_reg, bus.ALU_src_a, bus.ALU_src_b,
                bus.ALU_op, bus.Instr_done, bus.Illegal};

  localparam logic [14:0] V_IDLE    = 15'b0_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] V_FETCH1  = 15'b1_1_0_1_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] V_FETCH0  = 15'b0_0_0_1_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] V_EXEC_R  = 15'b0_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [14:0] V_EXEC_I  = 15'b0_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [14:0] V_EXEC_OR = 15'b0_0_0_0_0_0_0_0_1_10_11_0_0;
  localparam logic [14:0] V_WB_R    = 15'b0_0_0_0_0_1_1_0_0_00_00_1_0;
  localparam logic [14:0] V_WB_I    = 15'b0_0_0_0_0_1_0_0_0_00_00_1_0;
  localparam logic [14:0] V_MEM_RD  = 15'b0_0_1_1_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] V_WB_MEM  = 15'b0_0_0_0_0_1_0_1_0_00_00_1_0;
  localparam logic [14:0] V_MEM_WR0 = 15'b0_0_1_0_1_0_0_0_0_00_00_0_0;
  localparam logic [14:0] V_MEM_WR1 = 15'b0_0_1_0_1_0_0_0_0_00_00_1_0;
  localparam logic [14:0] V_ILL     = 15'b0_0_0_0_0_0_0_0_0_00_00_0_1;

  // Drive inputs just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic s, input logic r, input logic [5:0] op);
    @(negedge clk);
    bus.Start     = s;
    bus.Mem_ready = r;
    bus.OpCode    = op;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.Mem_ready = 1'b0; bus.OpCode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (obs !== V_IDLE) begin failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, V_IDLE); end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_IDLE) begin failures++; $display("FAIL idle_ignores_ready obs=%b exp=%b", obs, V_IDLE); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_IDLE) begin failures++; $display("FAIL idle_stays obs=%b exp=%b", obs, V_IDLE); end
  endtask

  task automatic test_rtype();
    drive(1'b1, 1'b1, 6'b000000);
    checks++; if (obs !== V_IDLE) begin failures++; $display("FAIL r_start obs=%b exp=%b", obs, V_IDLE); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL r_fetch obs=%b exp=%b", obs, V_FETCH1); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_DECODE) begin failures++; $display("FAIL r_decode obs=%b exp=%b", obs, V_DECODE); end
    drive(1'b0, 1'b0, 6'b111111);
    checks++; if (obs !== V_EXEC_R) begin failures++; $display("FAIL r_exec obs=%b exp=%b", obs, V_EXEC_R); end
    drive(1'b0, 1'b0, 6'b111111);
    checks++; if (obs !== V_WB_R) begin failures++; $display("FAIL r_wb obs=%b exp=%b", obs, V_WB_R); end
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL lw_fetch obs=%b exp=%b", obs, V_FETCH1); end
    drive(1'b1, 1'b1, 6'b100011);
    checks++; if (obs !== V_DECODE) begin failures++; $display("FAIL lw_decode obs=%b exp=%b", obs, V_DECODE); end
    drive(1'b1, 1'b1, 6'b000000);
    checks++; if (obs !== V_EXEC_I) begin failures++; $display("FAIL lw_exec obs=%b exp=%b", obs, V_EXEC_I); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_MEM_RD) begin failures++; $display("FAIL lw_memrd obs=%b exp=%b", obs, V_MEM_RD); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_WB_MEM) begin failures++; $display("FAIL lw_wbmem obs=%b exp=%b", obs, V_WB_MEM); end
  endtask

  task automatic test_sw_wait();
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL sw_fetch obs=%b exp=%b", obs, V_FETCH1); end
    drive(1'b0, 1'b1, 6'b101011);
    checks++; if (obs !== V_DECODE) begin failures++; $display("FAIL sw_decode obs=%b exp=%b", obs, V_DECODE); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_EXEC_I) begin failures++; $display("FAIL sw_exec obs=%b exp=%b", obs, V_EXEC_I); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 6'b000000);
      checks++; if (obs !== V_MEM_WR0) begin failures++; $display("FAIL sw_memwr_wait%0d obs=%b exp=%b", i, obs, V_MEM_WR0); end
    end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_MEM_WR1) begin failures++; $display("FAIL sw_memwr_done obs=%b exp=%b", obs, V_MEM_WR1); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_FETCH0) begin failures++; $display("FAIL sw_back_to_fetch obs=%b exp=%b", obs, V_FETCH0); end
  endtask

  task automatic test_fetch_wait_ori();
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_FETCH0) begin failures++; $display("FAIL ori_fetch_wait obs=%b exp=%b", obs, V_FETCH0); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL ori_fetch obs=%b exp=%b", obs, V_FETCH1); end
    drive(1'b0, 1'b0, 6'b001101);
    checks++; if (obs !== V_DECODE) begin failures++; $display("FAIL ori_decode obs=%b exp=%b", obs, V_DECODE); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_EXEC_OR) begin failures++; $display("FAIL ori_exec obs=%b exp=%b", obs, V_EXEC_OR); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== V_WB_I) begin failures++; $display("FAIL ori_wb obs=%b exp=%b", obs, V_WB_I); end
  endtask

  task automatic test_back_to_back_addiu();
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL addiu_fetch obs=%b exp=%b", obs, V_FETCH1); end
    drive(1'b0, 1'b1, 6'b001001);
    checks++; if (obs !== V_DECODE) begin failures++; $display("FAIL addiu_decode obs=%b exp=%b", obs, V_DECODE); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_EXEC_I) begin failures++; $display("FAIL addiu_exec obs=%b exp=%b", obs, V_EXEC_I); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_WB_I) begin failures++; $display("FAIL addiu_wb obs=%b exp=%b", obs, V_WB_I); end
  endtask

  task automatic test_illegal();
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL ill_fetch obs=%b exp=%b", obs, V_FETCH1); end
    drive(1'b0, 1'b1, 6'b000010);
    checks++; if (obs !== V_DECODE) begin failures++; $display("FAIL ill_decode obs=%b exp=%b", obs, V_DECODE); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_ILL) begin failures++; $display("FAIL ill_idle_flag obs=%b exp=%b", obs, V_ILL); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_ILL) begin failures++; $display("FAIL ill_idle_hold obs=%b exp=%b", obs, V_ILL); end
    drive(1'b1, 1'b1, 6'b000000);
    checks++; if (obs !== V_ILL) begin failures++; $display("FAIL ill_restart obs=%b exp=%b", obs, V_ILL); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== (V_FETCH1 | V_ILL)) begin failures++; $display("FAIL ill_sticky_fetch obs=%b exp=%b", obs, V_FETCH1 | V_ILL); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_ILL) begin failures++; $display("FAIL ill_sticky_decode obs=%b exp=%b", obs, V_ILL); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== (V_EXEC_R | V_ILL)) begin failures++; $display("FAIL ill_sticky_exec obs=%b exp=%b", obs, V_EXEC_R | V_ILL); end
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== (V_WB_R | V_ILL)) begin failures++; $display("FAIL ill_sticky_wb obs=%b exp=%b", obs, V_WB_R | V_ILL); end
  endtask

  // Starts in FETCH with Illegal still set from the previous scenario.
  task automatic test_reset_mid_write();
    drive(1'b0, 1'b1, 6'b000000);
    drive(1'b0, 1'b1, 6'b101011);
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== (V_EXEC_I | V_ILL)) begin failures++; $display("FAIL rst_sw_exec obs=%b exp=%b", obs, V_EXEC_I | V_ILL); end
    drive(1'b0, 1'b0, 6'b000000);
    checks++; if (obs !== (V_MEM_WR0 | V_ILL)) begin failures++; $display("FAIL rst_sw_memwr obs=%b exp=%b", obs, V_MEM_WR0 | V_ILL); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (obs !== V_IDLE) begin failures++; $display("FAIL rst_async_drop obs=%b exp=%b", obs, V_IDLE); end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_IDLE) begin failures++; $display("FAIL rst_after_idle obs=%b exp=%b", obs, V_IDLE); end
    drive(1'b1, 1'b1, 6'b000000);
    drive(1'b0, 1'b1, 6'b000000);
    checks++; if (obs !== V_FETCH1) begin failures++; $display("FAIL rst_restart_fetch obs=%b exp=%b", obs, V_FETCH1); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_rtype();
    test_lw();
    test_sw_wait();
    test_fetch_wait_ori();
    test_back_to_back_addiu();
    test_illegal();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
